neuromorphic_wb_master: RTL and testbench

Single-outstanding Wishbone classic (B4, non-pipelined) bus master that issues read/write transfers to the NEUROMORPHIC_X1 Wishbone slave port on behalf of a local command source (test sequencer, LA bridge or on-chip controller). It accepts one command on a valid/ready handshake, runs the bus cycle with a bounded ack timeout, and returns data/status on a valid/ready response channel. It is the initiator end of the same Wishbone link the ReRAM wrapper responds on.

---
 rtl/neuromorphic_wb_master.sv | 137 +++++++++++++
 tb/tb_neuromorphic_wb_master.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/neuromorphic_wb_master.sv
// neuromorphic_wb_master
//   Single-outstanding Wishbone classic (B4, non-pipelined) bus master.
//   Takes one command on a valid/ready handshake, runs one bus cycle with a
//   bounded ack timeout, then returns data/status on a valid/ready response.
//
// Ports
//   wb_clk_i, wb_rst_n_i       clock (rising edge), async active-low reset
//   cmd_valid_i / cmd_ready_o  command handshake
//   cmd_we/adr/dat/sel_i       command fields (1 = write)
//   rsp_valid_o / rsp_ready_i  response handshake
//   rsp_dat_o, rsp_err_o       read data (0 on write/timeout), timeout flag
//   wbm_*                      Wishbone master signals
//   busy_o                     high whenever the FSM is not idle
module neuromorphic_wb_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [ADDR_W-1:0]   cmd_adr_i,
  input  logic [DATA_W-1:0]   cmd_dat_i,
  input  logic [DATA_W/8-1:0] cmd_sel_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_dat_o,
  output logic                rsp_err_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [ADDR_W-1:0]   wbm_adr_o,
  output logic [DATA_W-1:0]   wbm_dat_o,
  output logic [DATA_W/8-1:0] wbm_sel_o,
  input  logic                wbm_ack_i,
  input  logic [DATA_W-1:0]   wbm_dat_i,
  output logic                busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]          state_q,   state_d;
  logic                ready_q,   ready_d;
  logic                we_q,      we_d;
  logic [ADDR_W-1:0]   adr_q,     adr_d;
  logic [DATA_W-1:0]   dat_q,     dat_d;
  logic [DATA_W/8-1:0] sel_q,     sel_d;
  logic [15:0]         cnt_q,     cnt_d;
  logic [DATA_W-1:0]   rsp_dat_q, rsp_dat_d;
  logic                rsp_err_q, rsp_err_d;

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && ready_q) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          sel_d   = cmd_sel_i;
          cnt_d   = '0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        // Ack is checked first so a same-cycle ack beats the timeout.
        if (wbm_ack_i) begin
          rsp_dat_d = we_q ? '0 : wbm_dat_i;
          rsp_err_d = 1'b0;
          state_d   = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          rsp_dat_d = '0;
          rsp_err_d = 1'b1;
          state_d   = S_RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Registered so it stays low during reset and rises on the first edge after.
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign wbm_cyc_o   = (state_q == S_BUS);
  assign wbm_stb_o   = (state_q == S_BUS);
  assign wbm_we_o    = we_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = sel_q;
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_neuromorphic_wb_master.sv
// Directed bench for neuromorphic_wb_master, built with TIMEOUT = 4.
module tb_neuromorphic_wb_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        cyc, stb, we;
  logic [31:0] adr, dat_o;
  logic [3:0]  sel;
  logic        ack = 1'b0;
  logic [31:0] dat_i = '0;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  neuromorphic_wb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_sel_o(sel),
    .wbm_ack_i(ack), .wbm_dat_i(dat_i), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_cyc", cyc, 0);
    chk("rst_stb", stb, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_adr", adr, 0);
    tick();
    chk("rst_hold_ready", cmd_ready, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", cmd_ready, 1);

    // Write, ack on the third stb cycle
    cmd_valid = 1; cmd_we = 1; cmd_adr = 32'h3000_0004;
    cmd_dat = 32'hA5A5_1234; cmd_sel = 4'hF; dat_i = 32'hDEAD_BEEF;
    tick();
    cmd_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("wr_cyc", cyc, 1);
      chk("wr_stb", stb, 1);
      chk("wr_we", we, 1);
      chk("wr_adr", adr, 64'h3000_0004);
      chk("wr_dat", dat_o, 64'hA5A5_1234);
      chk("wr_sel", sel, 4'hF);
      chk("wr_ready_low", cmd_ready, 0);
      if (i == 2) ack = 1;
      tick();
    end
    ack = 0;
    chk("wr_cyc_drop", cyc, 0);
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_err", rsp_err, 0);
    chk("wr_rsp_dat", rsp_dat, 0);
    chk("wr_adr_hold", adr, 64'h3000_0004);
    rsp_ready = 1;
    tick();
    chk("wr_rsp_done", rsp_valid, 0);
    chk("wr_ready_back", cmd_ready, 1);

    // Read, zero-wait slave, rsp_ready held high
    cmd_valid = 1; cmd_we = 0; cmd_adr = 32'h3000_0008;
    tick();
    cmd_valid = 0;
    chk("rd_stb", stb, 1);
    chk("rd_we", we, 0);
    ack = 1; dat_i = 32'h0000_00FF;
    tick();
    ack = 0; dat_i = 32'h1111_1111;
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_dat", rsp_dat, 64'hFF);
    chk("rd_rsp_err", rsp_err, 0);
    chk("rd_stb_drop", stb, 0);
    tick();
    chk("rd_ready_3cyc", cmd_ready, 1);
    chk("rd_busy_low", busy, 0);

    // Timeout: no ack, stb high exactly 4 cycles
    rsp_ready = 0; dat_i = 32'h9999_9999;
    cmd_valid = 1;
    tick();
    cmd_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("to_stb_high", stb, 1);
      tick();
    end
    chk("to_stb_low", stb, 0);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_dat", rsp_dat, 0);
    rsp_ready = 1;
    tick();
    chk("to_rsp_done", rsp_valid, 0);

    // Ack in the 4th (timeout) cycle: ack wins
    dat_i = 32'h1234_5678;
    cmd_valid = 1;
    tick();
    cmd_valid = 0;
    tick(); tick(); tick();
    chk("late_stb_4th", stb, 1);
    ack = 1;
    tick();
    ack = 0;
    chk("late_rsp_valid", rsp_valid, 1);
    chk("late_rsp_err", rsp_err, 0);
    chk("late_rsp_dat", rsp_dat, 64'h1234_5678);
    tick();
    chk("late_idle", cmd_ready, 1);

    // Backpressure with cmd_valid held high
    rsp_ready = 0;
    cmd_valid = 1; cmd_we = 0; cmd_adr = 32'h3000_0010;
    tick();
    cmd_we = 1; cmd_adr = 32'h3000_0020; cmd_dat = 32'h0BAD_F00D; cmd_sel = 4'h3;
    ack = 1; dat_i = 32'hCAFE_0001;
    chk("bp_adr_first", adr, 64'h3000_0010);
    tick();
    ack = 0; dat_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_dat", rsp_dat, 64'hCAFE_0001);
      chk("bp_rsp_err", rsp_err, 0);
      chk("bp_ready_low", cmd_ready, 0);
      chk("bp_cyc_low", cyc, 0);
      tick();
    end
    rsp_ready = 1;
    tick();
    chk("bp_rsp_done", rsp_valid, 0);
    chk("bp_ready_back", cmd_ready, 1);
    chk("bp_not_started", cyc, 0);
    tick();
    cmd_valid = 0;
    chk("bp2_cyc", cyc, 1);
    chk("bp2_we", we, 1);
    chk("bp2_adr", adr, 64'h3000_0020);
    chk("bp2_dat", dat_o, 64'h0BAD_F00D);
    chk("bp2_sel", sel, 4'h3);
    ack = 1;
    tick();
    ack = 0;
    chk("bp2_rsp_valid", rsp_valid, 1);
    chk("bp2_rsp_dat", rsp_dat, 0);
    tick();

    // Reset asserted mid-BUS
    rsp_ready = 0;
    cmd_valid = 1; cmd_we = 0; cmd_adr = 32'h3000_0040;
    tick();
    cmd_valid = 0;
    chk("rb_cyc_before", cyc, 1);
    #2 rst_n = 0;
    #1;
    chk("rb_cyc_async", cyc, 0);
    chk("rb_stb_async", stb, 0);
    chk("rb_busy_async", busy, 0);
    chk("rb_adr_async", adr, 0);
    chk("rb_ready_async", cmd_ready, 0);
    tick();
    rst_n = 1;
    tick();
    chk("rb_ready_after", cmd_ready, 1);
    chk("rb_no_rsp", rsp_valid, 0);
    // Stray ack in IDLE
    ack = 1; dat_i = 32'h0000_0055;
    tick();
    chk("stray_busy", busy, 0);
    chk("stray_rsp_valid", rsp_valid, 0);
    chk("stray_rsp_dat", rsp_dat, 0);
    tick();
    ack = 0;
    chk("stray_ready", cmd_ready, 1);
    // Normal command after reset
    cmd_valid = 1; cmd_we = 0; cmd_adr = 32'h3000_0044;
    tick();
    cmd_valid = 0;
    chk("rb2_adr", adr, 64'h3000_0044);
    ack = 1; dat_i = 32'h0000_0077;
    tick();
    ack = 0;
    chk("rb2_rsp_valid", rsp_valid, 1);
    chk("rb2_rsp_dat", rsp_dat, 64'h77);
    chk("rb2_rsp_err", rsp_err, 0);
    rsp_ready = 1;
    tick();
    chk("rb2_done", cmd_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
